// File: rtl/bfm_apb_slave.sv
// bfm_apb_slave: APB slave bus-functional model. Word-addressed memory,
// programmable wait states, completed-transfer counters and a sticky
// protocol-violation flag.
// Optional feature macro: BFM_APB_SLAVE_ERRRESP_EN -- when defined, addresses
// with PADDR[31:AWIDTH+2] nonzero get PSLVERR and no memory access; when
// undefined those upper bits are ignored and the memory aliases.
module bfm_apb_slave #(
  parameter int AWIDTH      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] WR_COUNT,
  output logic [15:0] RD_COUNT,
  output logic        PROT_ERR
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  // r_state only ever holds IDLE or ACCESS. SETUP is the bus cycle in which
  // PSEL rises with PENABLE low, so it is decoded from the bus in the same
  // cycle; that lets a back-to-back transfer go ACCESS->SETUP with no gap.
  logic [1:0]        r_state;
  logic [1:0]        w_state;
  logic [3:0]        r_wait;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic [15:0]       r_wr_cnt;
  logic [15:0]       r_rd_cnt;
  logic              r_prot;
  logic [31:0]       r_mem [0:(1<<AWIDTH)-1];
  logic [AWIDTH-1:0] w_word;
  logic              w_err;
  logic              w_done;
  logic              w_viol;
  logic              w_unused;

  assign w_word = PADDR[AWIDTH+1:2];

`ifdef BFM_APB_SLAVE_ERRRESP_EN
  assign w_err    = |PADDR[31:AWIDTH+2];
  assign PSLVERR  = PREADY & w_err;
  assign w_unused = ^PADDR[1:0];
`else
  assign w_err    = 1'b0;
  assign PSLVERR  = 1'b0;
  assign w_unused = ^{PADDR[1:0], PADDR[31:AWIDTH+2]};
`endif

  // Effective phase of the current bus cycle
  always_comb begin
    w_state = r_state;
    if (r_state != S_ACCESS)
      w_state = (PSEL && !PENABLE) ? S_SETUP : S_IDLE;
  end

  assign PREADY = (w_state == S_ACCESS) && (r_wait == 4'd0);
  assign w_done = PREADY && PSEL && PENABLE;
  assign PRDATA = (PREADY && !PWRITE && !w_err) ? r_mem[w_word] : 32'd0;

  // Any violation: PENABLE in IDLE, handshake dropped before completion,
  // or address/direction/data not held stable through the access phase.
  assign w_viol = ((w_state == S_IDLE) && PENABLE) ||
                  ((w_state == S_ACCESS) && !w_done && (!PSEL || !PENABLE)) ||
                  ((w_state == S_ACCESS) && PSEL &&
                   ((PADDR != r_addr) || (PWRITE != r_write) || (PWDATA != r_wdata)));

  // FSM, wait counter, setup-phase capture, counters and sticky error
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_wait   <= 4'd0;
      r_wr_cnt <= 16'd0;
      r_rd_cnt <= 16'd0;
      r_prot   <= 1'b0;
    end else begin
      case (w_state)
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_wait  <= 4'(WAIT_STATES);
          r_addr  <= PADDR;
          r_write <= PWRITE;
          r_wdata <= PWDATA;
        end
        S_ACCESS: begin
          if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
          if (w_done || !PSEL) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_done &&  PWRITE) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_done && !PWRITE) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_viol) r_prot <= 1'b1;
    end
  end

  // Memory write on completion; contents deliberately survive reset
  always_ff @(posedge PCLK) begin
    if (!PRESET && w_done && PWRITE && !PSLVERR)
      r_mem[w_word] <= PWDATA;
  end

  assign WR_COUNT = r_wr_cnt;
  assign RD_COUNT = r_rd_cnt;
  assign PROT_ERR = r_prot;

endmodule

// File: tb/tb_bfm_apb_slave.sv
// tb_bfm_apb_slave: two slaves (0 and 3 wait states) each on its own bus,
// directed scenarios plus randomized bursts checked against a flat memory
// and counter model.
module tb_bfm_apb_slave;
  localparam int AW = 8;

`ifdef BFM_APB_SLAVE_ERRRESP_EN
  localparam bit ERRRESP = 1'b1;
`else
  localparam bit ERRRESP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        psel [2];
  logic        pen [2];
  logic        pwr [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic [15:0] wrc [2];
  logic [15:0] rdc [2];
  logic        prot [2];

  bfm_apb_slave #(.AWIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(pen[0]),
    .PWRITE(pwr[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .WR_COUNT(wrc[0]), .RD_COUNT(rdc[0]), .PROT_ERR(prot[0]));

  bfm_apb_slave #(.AWIDTH(AW), .WAIT_STATES(3)) u_dut1 (
    .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(pen[1]),
    .PWRITE(pwr[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .WR_COUNT(wrc[1]), .RD_COUNT(rdc[1]), .PROT_ERR(prot[1]));

  // reference model
  int          wsv [2] = '{0, 3};
  logic [31:0] mmem [2][256];
  bit          mknown [2][256];
  int unsigned mwr [2];
  int unsigned mrd [2];
  bit          mprot [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input int d, input string tag);
    chk({tag, ".wrc"},  {16'd0, wrc[d]}, {16'd0, 16'(mwr[d])});
    chk({tag, ".rdc"},  {16'd0, rdc[d]}, {16'd0, 16'(mrd[d])});
    chk({tag, ".prot"}, {31'd0, prot[d]}, {31'd0, mprot[d]});
  endtask

  task automatic do_rst(input int d, input string tag);
    rst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0;
    tick(); tick();
    rst[d] = 1'b0;
    mwr[d] = 0; mrd[d] = 0; mprot[d] = 1'b0;
    @(negedge clk);
    chk({tag, ".prdy"},   {31'd0, pready[d]},  32'd0);
    chk({tag, ".pslv"},   {31'd0, pslverr[d]}, 32'd0);
    chk({tag, ".prdata"}, prdata[d],           32'd0);
    chk_state(d, tag);
    tick();
  endtask

  // One full transfer starting just after an edge; leaves the bus idle
  // unless b2b, in which case the next call supplies the SETUP cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input bit b2b, input string tag);
    int  w;
    int  acyc;
    bit  err;
    w   = int'((a >> 2) & 32'hFF);
    err = ERRRESP && ((a >> 10) != 0);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    chk({tag, ".setup_rdy"}, {31'd0, pready[d]}, 32'd0);
    chk({tag, ".setup_rd"},  prdata[d], 32'd0);
    tick();
    pen[d] = 1'b1;
    acyc = 0;
    do begin
      @(negedge clk);
      acyc++;
      if (!pready[d]) chk({tag, ".wait_slv"}, {31'd0, pslverr[d]}, 32'd0);
    end while (!pready[d] && acyc < 40);
    chk({tag, ".acyc"}, acyc, wsv[d] + 1);
    chk({tag, ".slverr"}, {31'd0, pslverr[d]}, {31'd0, err});
    if (wr || err)
      chk({tag, ".rdata"}, prdata[d], 32'd0);
    else if (mknown[d][w])
      chk({tag, ".rdata"}, prdata[d], mmem[d][w]);
    tick();
    if (wr) begin
      mwr[d]++;
      if (!err) begin mmem[d][w] = wd; mknown[d][w] = 1'b1; end
    end else begin
      mrd[d]++;
    end
    if (!b2b) begin psel[d] = 1'b0; pen[d] = 1'b0; end
    chk_state(d, tag);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      paddr[d] = 32'd0; pwdata[d] = 32'd0;
      mwr[d] = 0; mrd[d] = 0; mprot[d] = 1'b0;
      for (int i = 0; i < 256; i++) begin mknown[d][i] = 1'b0; mmem[d][i] = 32'd0; end
    end
    do_rst(0, "rst0");
    do_rst(1, "rst1");

    // zero-wait write then read
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "w10");
    xfer(0, 1'b0, 32'h10, 32'h0,        1'b0, "r10");

    // three wait states on a read
    xfer(1, 1'b1, 32'h0, 32'h0BADF00D, 1'b0, "w1_0");
    xfer(1, 1'b0, 32'h0, 32'h0,        1'b0, "r1_0");

    // back-to-back write/read with PSEL held
    xfer(0, 1'b1, 32'h4, 32'h1, 1'b1, "b2b_w");
    xfer(0, 1'b0, 32'h4, 32'h0, 1'b0, "b2b_r");

    // out-of-range address: error response or alias onto word 0
    xfer(0, 1'b1, 32'h0,   32'hA5A5A5A5, 1'b0, "w0");
    xfer(0, 1'b1, 32'h400, 32'h55,       1'b0, "woor");
    xfer(0, 1'b0, 32'h0,   32'h0,        1'b0, "r0");
    xfer(0, 1'b0, 32'h400, 32'h0,        1'b0, "roor");

    // randomized bursts
    for (int b = 0; b < 40; b++) begin
      int d, len;
      d   = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = a | ($urandom_range(1, 255) << 10);
        xfer(d, 1'($urandom), a, $urandom, k < len - 1, "rnd");
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    // abort: PSEL dropped in access cycle 2 of a 3-wait write
    xfer(1, 1'b1, 32'h8, 32'h12345678, 1'b0, "pre8");
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'hBAD0BAD0;
    tick(); pen[1] = 1'b1;
    tick();
    psel[1] = 1'b0; pen[1] = 1'b0;
    tick();
    mprot[1] = 1'b1;
    chk_state(1, "abort");
    xfer(1, 1'b0, 32'h8, 32'h0, 1'b0, "abort_rd");
    tick(); tick(); tick();
    chk("abort_sticky", {31'd0, prot[1]}, 32'd1);
    do_rst(1, "abort_rst");

    // PENABLE high while idle
    pen[0] = 1'b1;
    tick();
    pen[0] = 1'b0;
    mprot[0] = 1'b1;
    chk_state(0, "idle_pen");
    do_rst(0, "idle_pen_rst");

    // address changed during access phase of a read
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b0; paddr[1] = 32'hC; pwdata[1] = 32'h0;
    tick(); pen[1] = 1'b1; paddr[1] = 32'h10;
    tick(); tick(); tick(); tick();
    psel[1] = 1'b0; pen[1] = 1'b0;
    mrd[1]++; mprot[1] = 1'b1;
    chk_state(1, "addr_chg");
    do_rst(1, "addr_chg_rst");

    // reset during ACCESS: no write, no count, memory kept
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'hCAFECAFE;
    tick(); pen[1] = 1'b1;
    tick();
    do_rst(1, "rst_acc1");
    xfer(1, 1'b0, 32'h8, 32'h0, 1'b0, "rst_acc1_rd");
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'hFFFF0000;
    tick(); pen[0] = 1'b1;
    do_rst(0, "rst_acc0");
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, "rst_acc0_rd");
    do_rst(0, "wrap_rst");

    // 65536 back-to-back writes: WR_COUNT wraps to zero
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) chk("wrap_ffff", {16'd0, wrc[0]}, 32'hFFFF);
      psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 32'h20; pwdata[0] = i;
      tick(); pen[0] = 1'b1;
      tick();
    end
    psel[0] = 1'b0; pen[0] = 1'b0;
    mwr[0] += 65536; mmem[0][8] = 32'd65535; mknown[0][8] = 1'b1;
    chk_state(0, "wrap");
    xfer(0, 1'b0, 32'h20, 32'h0, 1'b0, "wrap_rd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
